// File: rtl/tmds_rx_align_decode.sv
// TMDS receive channel: hunts word alignment by pulsing bitslip until a run of
// control tokens appears, then decodes each 10-bit word to pixel/control data.
module tmds_rx_align_decode #(
  parameter int CTRL_RUN   = 16,
  parameter int SEARCH_LEN = 4096,
  parameter int SLIP_WAIT  = 4
) (
  input  logic       i_clk,
  input  logic       i_srst_n,
  input  logic [9:0] i_raw_word,
  output logic       o_bitslip,
  output logic       o_locked,
  output logic       o_de,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl
);

  localparam int TMO_MAX = (SEARCH_LEN > SLIP_WAIT) ? SEARCH_LEN : SLIP_WAIT;
  localparam int TMO_W   = $clog2(TMO_MAX) + 1;
  localparam int RUN_W   = $clog2(CTRL_RUN + 1);

  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(SEARCH_LEN - 1);
  localparam logic [TMO_W-1:0] SLIP_LAST = TMO_W'(SLIP_WAIT - 1);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(CTRL_RUN - 1);
  localparam logic [RUN_W-1:0] RUN_FULL  = RUN_W'(CTRL_RUN);

  typedef enum logic [1:0] {SEARCH, SLIP, LOCKED} state_t;

  // {is_token, ctrl}
  function automatic logic [2:0] token_lookup(input logic [9:0] w);
    case (w)
      10'h354: token_lookup = 3'b100;
      10'h0AB: token_lookup = 3'b101;
      10'h154: token_lookup = 3'b110;
      10'h2AB: token_lookup = 3'b111;
      default: token_lookup = 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q    = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  state_t           state_q, state_nx;
  logic [RUN_W-1:0] run_cnt, run_nx;
  logic [TMO_W-1:0] tmo_cnt, tmo_nx;

  logic       tok_p0;
  logic [1:0] ctrl_p0;
  logic [7:0] d_p0;
  logic       lock_p0;

  logic       bitslip_nx, locked_nx, de_nx;
  logic [7:0] data_nx;
  logic [1:0] ctrl_nx;

  // ---- stage p0: combinational classify/decode of the incoming word ----
  always_comb begin
    {tok_p0, ctrl_p0} = token_lookup(i_raw_word);
    d_p0              = tmds_decode(i_raw_word);
    lock_p0           = tok_p0 && (run_cnt == RUN_LAST);
  end

  always_comb begin
    state_nx = state_q;
    run_nx   = run_cnt;
    tmo_nx   = tmo_cnt;
    unique case (state_q)
      SEARCH: begin
        if (lock_p0) begin
          state_nx = LOCKED;
          run_nx   = RUN_FULL;
          tmo_nx   = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx = SLIP;
          run_nx   = '0;
          tmo_nx   = '0;
        end else begin
          run_nx = tok_p0 ? run_cnt + RUN_W'(1) : '0;
          tmo_nx = tmo_cnt + TMO_W'(1);
        end
      end
      // Deserializer is still settling; tmo_cnt doubles as the wait counter.
      SLIP: begin
        run_nx = '0;
        if (tmo_cnt == SLIP_LAST) begin
          state_nx = SEARCH;
          tmo_nx   = '0;
        end else begin
          tmo_nx = tmo_cnt + TMO_W'(1);
        end
      end
      LOCKED: begin
        if (tok_p0) begin
          tmo_nx = '0;
          run_nx = (run_cnt == RUN_FULL) ? run_cnt : run_cnt + RUN_W'(1);
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx = SEARCH;
          run_nx   = '0;
          tmo_nx   = '0;
        end else begin
          run_nx = '0;
          tmo_nx = tmo_cnt + TMO_W'(1);
        end
      end
      default: begin
        state_nx = SEARCH;
        run_nx   = '0;
        tmo_nx   = '0;
      end
    endcase
  end

  always_comb begin
    bitslip_nx = (state_q == SEARCH) && (state_nx == SLIP);
    locked_nx  = (state_nx == LOCKED);
    de_nx      = (state_q == LOCKED) && (state_nx == LOCKED) && !tok_p0;
    data_nx    = de_nx ? d_p0 : 8'h00;
    ctrl_nx    = 2'b00;
    if (state_nx == LOCKED) begin
      ctrl_nx = tok_p0 ? ctrl_p0 : o_ctrl;
    end
  end

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      state_q   <= SEARCH;
      run_cnt   <= '0;
      tmo_cnt   <= '0;
      o_bitslip <= 1'b0;
      o_locked  <= 1'b0;
      o_de      <= 1'b0;
      o_data    <= 8'h00;
      o_ctrl    <= 2'b00;
    end else begin
      state_q   <= state_nx;
      run_cnt   <= run_nx;
      tmo_cnt   <= tmo_nx;
      o_bitslip <= bitslip_nx;
      o_locked  <= locked_nx;
      o_de      <= de_nx;
      o_data    <= data_nx;
      o_ctrl    <= ctrl_nx;
    end
  end

endmodule

// File: tb/tb_tmds_rx_align_decode.sv
// Bench for tmds_rx_align_decode: directed vectors, a behavioural reference
// model updated per edge, and a deserializer model that honours bitslip.
module tb_tmds_rx_align_decode;

  localparam int CTRL_RUN   = 16;
  localparam int SEARCH_LEN = 64;
  localparam int SLIP_WAIT  = 4;

  logic       clk = 1'b0;
  logic       srst_n;
  logic [9:0] raw_word;
  logic       bitslip, locked, de;
  logic [7:0] data;
  logic [1:0] ctrl;

  always #5 clk = ~clk;

  tmds_rx_align_decode #(
    .CTRL_RUN  (CTRL_RUN),
    .SEARCH_LEN(SEARCH_LEN),
    .SLIP_WAIT (SLIP_WAIT)
  ) dut (
    .i_clk     (clk),
    .i_srst_n  (srst_n),
    .i_raw_word(raw_word),
    .o_bitslip (bitslip),
    .o_locked  (locked),
    .o_de      (de),
    .o_data    (data),
    .o_ctrl    (ctrl)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state and expected registered outputs
  logic [9:0] tok_code [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  bit         m_valid = 0;
  bit         m_locked = 0;
  int         m_wait = 0, m_age = 0, m_run = 0;
  logic       e_bitslip, e_locked, e_de;
  logic [7:0] e_data;
  logic [1:0] e_ctrl;

  // Invert the TMDS transition-minimising stage by searching all bytes.
  function automatic logic [7:0] model_decode(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    logic [7:0] enc;
    q = w[9] ? ~w[7:0] : w[7:0];
    for (int v = 0; v < 256; v++) begin
      d      = 8'(v);
      enc[0] = d[0];
      for (int i = 1; i < 8; i++) enc[i] = w[8] ? (enc[i-1] ^ d[i]) : ~(enc[i-1] ^ d[i]);
      if (enc == q) return d;
    end
    return 8'h00;
  endfunction

  task automatic model_step(input logic [9:0] w, input logic rn);
    int c;
    c = -1;
    for (int k = 0; k < 4; k++) if (w == tok_code[k]) c = k;
    e_bitslip = 1'b0;
    e_de      = 1'b0;
    e_data    = 8'h00;
    if (!rn) begin
      m_locked = 0; m_wait = 0; m_age = 0; m_run = 0;
      e_locked = 1'b0; e_ctrl = 2'b00;
    end else if (m_wait > 0) begin
      m_wait--;
      e_locked = 1'b0; e_ctrl = 2'b00;
    end else if (!m_locked) begin
      m_run = (c >= 0) ? m_run + 1 : 0;
      if (m_run >= CTRL_RUN) begin
        m_locked = 1; m_age = 0;
        e_locked = 1'b1; e_ctrl = 2'(c);
      end else begin
        e_locked = 1'b0; e_ctrl = 2'b00;
        if (m_age == SEARCH_LEN - 1) begin
          e_bitslip = 1'b1; m_wait = SLIP_WAIT; m_run = 0; m_age = 0;
        end else begin
          m_age++;
        end
      end
    end else begin
      if (c >= 0) begin
        e_ctrl = 2'(c); m_age = 0;
      end else begin
        m_age++;
        if (m_age == SEARCH_LEN) begin
          m_locked = 0; m_run = 0; m_age = 0;
          e_locked = 1'b0; e_ctrl = 2'b00;
        end else begin
          e_de = 1'b1; e_data = model_decode(w);
        end
      end
    end
    m_valid = 1;
  endtask

  // One clock: apply word, let the edge happen, advance model, settle.
  task automatic drive(input logic [9:0] w);
    raw_word = w;
    @(posedge clk);
    model_step(w, srst_n);
    #1;
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("bitslip", {31'd0, bitslip}, {31'd0, e_bitslip});
      chk("locked",  {31'd0, locked},  {31'd0, e_locked});
      chk("de",      {31'd0, de},      {31'd0, e_de});
      chk("data",    {24'd0, data},    {24'd0, e_data});
      chk("ctrl",    {30'd0, ctrl},    {30'd0, e_ctrl});
    end
  end

  // Transmit stream for the alignment search: 20 tokens every 50 words.
  function automatic logic [9:0] tx_word(input int k);
    return ((k % 50) < 20) ? 10'h354 : 10'h100;
  endfunction

  function automatic logic [9:0] rx_word(input int j, input int a);
    logic [9:0] w;
    logic [9:0] t;
    int n;
    for (int b = 0; b < 10; b++) begin
      n    = 10 * j + a + b;
      t    = tx_word(n / 10);
      w[b] = t[n % 10];
    end
    return w;
  endfunction

  initial begin
    int a, j, slips, pulses;
    logic [9:0] rst_words [5];
    rst_words = '{10'h354, 10'h354, 10'h2AB, 10'h123, 10'h354};
    srst_n   = 1'b0;
    raw_word = 10'h000;

    // Reset
    for (int i = 0; i < 5; i++) drive(rst_words[i]);
    chk("rst_outputs", {19'd0, bitslip, locked, de, data, ctrl}, 32'd0);
    srst_n = 1'b1;

    // Clean lock and decode
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      drive(10'h354);
      if (bitslip) pulses++;
      if (i == 15) chk("clean_pre_lock", {31'd0, locked}, 32'd0);
    end
    chk("clean_lock", {31'd0, locked}, 32'd1);
    chk("clean_lock_ctrl", {30'd0, ctrl}, 32'd0);
    drive(10'h100);
    chk("dec_100", {23'd0, de, data}, {23'd0, 1'b1, 8'h00});
    drive(10'h200);
    chk("dec_200", {23'd0, de, data}, {23'd0, 1'b1, 8'hFF});
    drive(10'h0AB);
    chk("ctrl_01", {29'd0, de, ctrl}, {29'd0, 1'b0, 2'b01});
    chk("clean_no_slip", pulses, 32'd0);

    // Lock loss after SEARCH_LEN data words
    for (int i = 1; i <= SEARCH_LEN; i++) begin
      drive(10'h100);
      if (i == SEARCH_LEN - 1) chk("loss_pre", {30'd0, locked, de}, 32'd3);
    end
    chk("loss_drop", {29'd0, bitslip, locked, de}, 32'd0);

    // Broken run
    for (int i = 0; i < 15; i++) drive(10'h154);
    drive(10'h100);
    for (int i = 0; i < 15; i++) drive(10'h154);
    chk("broken_no_lock", {31'd0, locked}, 32'd0);
    drive(10'h154);
    chk("broken_lock", {29'd0, locked, ctrl}, {29'd0, 1'b1, 2'b10});

    // Reset mid-lock
    drive(10'h100);
    chk("midlock_de", {23'd0, de, data}, {23'd0, 1'b1, 8'h00});
    srst_n = 1'b0;
    drive(10'h200);
    chk("midlock_rst", {19'd0, bitslip, locked, de, data, ctrl}, 32'd0);
    srst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      drive(10'h2AB);
      if (i == 15) chk("relock_pre", {31'd0, locked}, 32'd0);
    end
    chk("relock", {29'd0, locked, ctrl}, {29'd0, 1'b1, 2'b11});

    // Alignment search from a 3-bit offset
    srst_n = 1'b0;
    drive(10'h000);
    drive(10'h000);
    srst_n = 1'b1;
    a = 3; j = 0; slips = 0;
    for (int n = 0; n < 600 && !locked; n++) begin
      drive(rx_word(j, a));
      j++;
      if (bitslip) begin
        slips++;
        a = (a + 9) % 10;
      end
    end
    chk("slip_count", slips, 32'd3);
    chk("slip_locked", {31'd0, locked}, 32'd1);
    drive(rx_word(j, a));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
